// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the two-way write-back cache
//
// Purpose: line/word types, default geometry constants and the controller
// state encoding used by cache_core and cache_way.
// Ports: none (package).

package cache_pkg;

  localparam int ADR_W  = 12;            // line address width (byte address [15:4])
  localparam int LINE_W = 128;           // bits per cache line
  localparam int SEL_W  = LINE_W / 8;    // byte enables per line
  localparam int IDX_W  = 3;             // default index width (8 sets)
  localparam int TAG_W  = ADR_W - IDX_W; // default tag width

  localparam logic [SEL_W-1:0] SEL_ALL = '1;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [15:0]       word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_t;

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one way of the cache: valid/dirty/tag/data arrays, tag compare
//
// Purpose: storage for one way across all sets. Reads are combinational at
// i_idx; a byte-masked CPU write sets dirty, a refill loads a whole line clean.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears valid/dirty)
//   i_idx                    set index for read, compare and both write paths
//   i_tag                    tag compared against the stored tag
//   i_wr_en/i_wr_sel/i_wr_data   byte-masked write of the selected line, marks dirty
//   i_fill_en/i_fill_tag/i_fill_data  full-line refill, marks valid and clean
//   o_hit                    valid and tag match
//   o_valid/o_dirty/o_tag/o_data  stored state of the selected set

module cache_way
  import cache_pkg::*;
#(
  parameter int SETS      = 8,
  parameter int TAG_W     = 9,
  parameter int IDX_W     = 3,
  parameter int LINE_BITS = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic                   i_wr_en,
  input  logic [LINE_BITS/8-1:0] i_wr_sel,
  input  logic [LINE_BITS-1:0]   i_wr_data,
  input  logic                   i_fill_en,
  input  logic [TAG_W-1:0]       i_fill_tag,
  input  logic [LINE_BITS-1:0]   i_fill_data,
  output logic                   o_hit,
  output logic                   o_valid,
  output logic                   o_dirty,
  output logic [TAG_W-1:0]       o_tag,
  output logic [LINE_BITS-1:0]   o_data
);

  localparam int NB = LINE_BITS / 8;

  logic [SETS-1:0]      r_valid;
  logic [SETS-1:0]      r_dirty;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [LINE_BITS-1:0] r_data [SETS];

  logic [LINE_BITS-1:0] w_merged;

  always_comb begin
    w_merged = r_data[i_idx];
    for (int i = 0; i < NB; i++) begin
      if (i_wr_sel[i]) w_merged[8*i +: 8] = i_wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_wr_en) begin
      r_data[i_idx] <= w_merged;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
  assign o_hit   = r_valid[i_idx] & (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/cache_core.sv
// rtl/cache_core.sv - two-way set-associative write-back cache controller and datapath
//
// Purpose: serves CPU line reads/writes from two ways; hits ack in the request
// cycle, misses write back a dirty LRU victim and refill from memory.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_cyc/cpu_stb/cpu_we/cpu_adr/cpu_sel/cpu_dat_i   CPU request
//   cpu_dat_o/cpu_ack/cpu_rty         CPU response (rty = request pending, not acked)
//   mem_cyc/mem_stb/mem_we/mem_adr/mem_sel/mem_dat_o   memory request
//   mem_dat_i/mem_ack/mem_rty         memory response
//   miss_count                        count of memory acks, wraps

module cache_core
  import cache_pkg::*;
#(
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_cyc,
  input  logic                   cpu_stb,
  input  logic                   cpu_we,
  input  logic [ADR_W-1:0]       cpu_adr,
  input  logic [LINE_BITS/8-1:0] cpu_sel,
  input  logic [LINE_BITS-1:0]   cpu_dat_i,
  output logic [LINE_BITS-1:0]   cpu_dat_o,
  output logic                   cpu_ack,
  output logic                   cpu_rty,
  output logic                   mem_cyc,
  output logic                   mem_stb,
  output logic                   mem_we,
  output logic [ADR_W-1:0]       mem_adr,
  output logic [LINE_BITS/8-1:0] mem_sel,
  output logic [LINE_BITS-1:0]   mem_dat_o,
  input  logic [LINE_BITS-1:0]   mem_dat_i,
  input  logic                   mem_ack,
  input  logic                   mem_rty,
  output word_t                  miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADR_W - IW;

  state_t           r_state;
  state_t           w_state_next;
  logic [SETS-1:0]  r_lru;        // per set: 1 = way1 is least recently used
  logic [ADR_W-1:0] r_mar;        // latched request address for the whole miss
  logic             r_victim;     // way being replaced during the miss
  word_t            r_miss_count;

  logic [IW-1:0]        w_idx;
  logic [TW-1:0]        w_req_tag;
  logic                 w_req;
  logic                 w_hit0, w_hit1, w_hit;
  logic                 w_valid0, w_valid1, w_dirty0, w_dirty1;
  logic [TW-1:0]        w_tag0, w_tag1;
  logic [LINE_BITS-1:0] w_data0, w_data1;
  logic                 w_ack;
  logic                 w_wr0, w_wr1;
  logic                 w_fill, w_fill0, w_fill1;
  logic                 w_victim;
  logic                 w_vic_valid, w_vic_dirty;
  logic [TW-1:0]        w_vic_tag;
  logic [LINE_BITS-1:0] w_vic_data;
  logic                 w_miss_start;
  logic                 w_mem_retry;

  // In IDLE the arrays are addressed by the live request; during a miss by the MAR.
  assign w_idx     = (r_state == ST_IDLE) ? cpu_adr[IW-1:0] : r_mar[IW-1:0];
  assign w_req_tag = cpu_adr[ADR_W-1:IW];
  assign w_req     = cpu_cyc & cpu_stb;
  assign w_hit     = w_hit0 | w_hit1;

  assign w_ack        = ~rst & (r_state == ST_IDLE) & w_req & w_hit;
  assign w_miss_start = ~rst & (r_state == ST_IDLE) & w_req & ~w_hit;
  assign w_wr0        = w_ack & cpu_we & w_hit0;
  assign w_wr1        = w_ack & cpu_we & w_hit1;

  assign w_fill  = ~rst & (r_state == ST_ALLOCATE) & mem_ack;
  assign w_fill0 = w_fill & ~r_victim;
  assign w_fill1 = w_fill & r_victim;

  assign w_victim    = (r_state == ST_IDLE) ? r_lru[w_idx] : r_victim;
  assign w_vic_valid = w_victim ? w_valid1 : w_valid0;
  assign w_vic_dirty = w_victim ? w_dirty1 : w_dirty0;
  assign w_vic_tag   = w_victim ? w_tag1   : w_tag0;
  assign w_vic_data  = w_victim ? w_data1  : w_data0;

  assign w_mem_retry = mem_rty & ~mem_ack;

  cache_way #(
    .SETS(SETS), .TAG_W(TW), .IDX_W(IW), .LINE_BITS(LINE_BITS)
  ) u_way0 (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (w_idx),
    .i_tag      (w_req_tag),
    .i_wr_en    (w_wr0),
    .i_wr_sel   (cpu_sel),
    .i_wr_data  (cpu_dat_i),
    .i_fill_en  (w_fill0),
    .i_fill_tag (r_mar[ADR_W-1:IW]),
    .i_fill_data(mem_dat_i),
    .o_hit      (w_hit0),
    .o_valid    (w_valid0),
    .o_dirty    (w_dirty0),
    .o_tag      (w_tag0),
    .o_data     (w_data0)
  );

  cache_way #(
    .SETS(SETS), .TAG_W(TW), .IDX_W(IW), .LINE_BITS(LINE_BITS)
  ) u_way1 (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (w_idx),
    .i_tag      (w_req_tag),
    .i_wr_en    (w_wr1),
    .i_wr_sel   (cpu_sel),
    .i_wr_data  (cpu_dat_i),
    .i_fill_en  (w_fill1),
    .i_fill_tag (r_mar[ADR_W-1:IW]),
    .i_fill_data(mem_dat_i),
    .o_hit      (w_hit1),
    .o_valid    (w_valid1),
    .o_dirty    (w_dirty1),
    .o_tag      (w_tag1),
    .o_data     (w_data1)
  );

  always_comb begin
    w_state_next = r_state;
    mem_cyc      = 1'b0;
    mem_stb      = 1'b0;
    mem_we       = 1'b0;
    mem_adr      = '0;
    mem_dat_o    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !w_hit) begin
          w_state_next = (w_vic_valid && w_vic_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_cyc   = 1'b1;
        mem_stb   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = {w_vic_tag, r_mar[IW-1:0]};
        mem_dat_o = w_vic_data;
        if (mem_ack)          w_state_next = ST_ALLOCATE;
        else if (w_mem_retry) w_state_next = ST_WRITEBACK;
      end
      ST_ALLOCATE: begin
        mem_cyc = 1'b1;
        mem_stb = 1'b1;
        mem_adr = r_mar;
        if (mem_ack)          w_state_next = ST_IDLE;
        else if (w_mem_retry) w_state_next = ST_ALLOCATE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lru        <= '0;
      r_mar        <= '0;
      r_victim     <= 1'b0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss_start) begin
        r_mar    <= cpu_adr;
        r_victim <= r_lru[w_idx];
      end
      // The way just used becomes most recent, so the other one is now LRU.
      if (w_ack) r_lru[w_idx] <= w_hit0;
      if (mem_cyc && mem_ack) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign cpu_ack    = w_ack;
  assign cpu_rty    = cpu_cyc & cpu_stb & ~w_ack;
  assign cpu_dat_o  = w_hit1 ? w_data1 : w_data0;
  assign mem_sel    = SEL_ALL[LINE_BITS/8-1:0];
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cache_core.sv
// tb/tb_cache_core.sv - scoreboard bench for cache_core against a flat-memory reference

module tb_cache_core;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cyc, cpu_stb, cpu_we;
  logic [11:0] cpu_adr;
  logic [15:0] cpu_sel;
  line_t       cpu_dat_i, cpu_dat_o;
  logic        cpu_ack, cpu_rty;
  logic        mem_cyc, mem_stb, mem_we;
  logic [11:0] mem_adr;
  logic [15:0] mem_sel;
  line_t       mem_dat_o, mem_dat_i;
  logic        mem_ack, mem_rty;
  word_t       miss_count;

  always #5 clk = ~clk;

  cache_core #(.SETS(8), .LINE_BITS(128)) dut (
    .clk(clk), .rst(rst),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_sel(cpu_sel), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o),
    .cpu_ack(cpu_ack), .cpu_rty(cpu_rty),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_sel(mem_sel), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_ack(mem_ack), .mem_rty(mem_rty), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the CPU sees a flat memory of lines; the backing store is what memory holds.
  line_t ref_mem   [int];
  line_t mem_store [int];

  function automatic line_t init_line(input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    return {4{a16 ^ 16'h5A3C, a16 + 16'h1111}};
  endfunction

  function automatic line_t ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic line_t mem_rd(input int a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_line(a);
  endfunction

  function automatic line_t merge(input line_t o, input line_t d, input logic [15:0] s);
    line_t r;
    r = o;
    for (int i = 0; i < 16; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Cache occupancy model: per set, resident line addresses most-recent first.
  typedef struct {
    logic        we;
    logic [11:0] adr;
    line_t       dat;
  } mem_txn_t;

  int       res [8][$];
  bit       dirty_m [int];
  int       exp_miss = 0;
  line_t    cpu_q [$];
  mem_txn_t mem_q [$];

  task automatic model_access(input int a, input bit we, output bit hit);
    int s, k, v;
    mem_txn_t t;
    s   = a % 8;
    hit = 0;
    k   = -1;
    for (int i = 0; i < res[s].size(); i++) if (res[s][i] == a) k = i;
    if (k >= 0) begin
      hit = 1;
      res[s].delete(k);
    end else begin
      if (res[s].size() == 2) begin
        v = res[s][1];
        if (dirty_m.exists(v) && dirty_m[v]) begin
          t.we = 1; t.adr = v[11:0]; t.dat = ref_rd(v);
          mem_q.push_back(t);
          exp_miss++;
        end
        dirty_m[v] = 0;
        void'(res[s].pop_back());
      end
      t.we = 0; t.adr = a[11:0]; t.dat = '0;
      mem_q.push_back(t);
      exp_miss++;
      dirty_m[a] = 0;
    end
    res[s].push_front(a);
    if (we) dirty_m[a] = 1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) res[s].delete();
    dirty_m.delete();
    ref_mem  = mem_store;
    exp_miss = 0;
    cpu_q.delete();
    mem_q.delete();
  endtask

  // One CPU request; call at posedge+1, returns at posedge+1 with the bus idle.
  task automatic do_req(input int a, input bit we, input logic [15:0] sel, input line_t d);
    bit    hit;
    line_t old;
    int    n;
    old = ref_rd(a);
    model_access(a, we, hit);
    cpu_q.push_back(old);
    if (we) ref_mem[a] = merge(old, d, sel);
    cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_adr = a[11:0]; cpu_sel = sel; cpu_dat_i = d;
    @(negedge clk);
    check("ack_first_cycle_iff_hit", cpu_ack, hit);
    check("cpu_rty", cpu_rty, !hit);
    n = 0;
    while (!cpu_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("cpu_ack_within_budget", cpu_ack, 1);
    @(posedge clk); #1;
    cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
    check("miss_count", miss_count, exp_miss);
  endtask

  // CPU response monitor.
  always @(negedge clk) begin : cpu_mon
    line_t e;
    if (cpu_cyc && cpu_stb && cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_ack_unexpected", cpu_ack, 0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_dat_o", cpu_dat_o, e);
      end
    end
  end

  // Memory responder and memory-traffic monitor.
  bit hold_mem = 0;
  bit force_rty3 = 0;
  int delay = 0;
  bit prev_rty = 0;
  logic [11:0] prev_adr;

  initial begin : mem_side
    mem_txn_t t;
    mem_ack = 0; mem_rty = 0; mem_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (prev_rty && !rst) begin
        check("rty_hold_cyc", mem_cyc, 1);
        check("rty_hold_stb", mem_stb, 1);
        check("rty_hold_adr", mem_adr, prev_adr);
      end
      prev_rty = 0;
      if (mem_ack) begin
        mem_ack = 0;
        mem_rty = 0;
        delay = force_rty3 ? 3 : $urandom_range(0, 3);
      end else if (mem_cyc && !hold_mem && !rst) begin
        check("mem_stb", mem_stb, 1);
        check("mem_sel", mem_sel, 16'hFFFF);
        if (delay > 0) begin
          delay--;
          mem_rty = force_rty3 ? 1'b1 : 1'($urandom_range(0, 1));
          prev_rty = mem_rty;
          prev_adr = mem_adr;
        end else begin
          mem_rty = 0;
          mem_ack = 1;
          if (mem_q.size() == 0) check("mem_txn_unexpected", mem_cyc, 0);
          else begin
            t = mem_q.pop_front();
            check("mem_we", mem_we, t.we);
            check("mem_adr", mem_adr, t.adr);
            if (t.we) check("wb_data", mem_dat_o, t.dat);
          end
          if (mem_we) mem_store[int'(mem_adr)] = mem_dat_o;
          else mem_dat_i = mem_rd(int'(mem_adr));
        end
      end else begin
        mem_rty = 0;
      end
    end
  end

  initial begin : main
    int    n;
    line_t d;
    rst = 1; cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_adr = '0; cpu_sel = '0; cpu_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_cyc", mem_cyc, 0);
    check("rst_mem_stb", mem_stb, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_miss_count", miss_count, 0);
    @(posedge clk); #1;
    rst = 0;
    delay = 1;

    // Directed walk through one set.
    mem_store[16] = {16{8'hA5}};
    ref_mem[16]   = {16{8'hA5}};
    do_req(12'h010, 0, 16'h0000, '0);
    do_req(12'h010, 0, 16'h0000, '0);
    d = {$urandom, $urandom, $urandom, 16'h1234, 16'hBEEF};
    do_req(12'h010, 1, 16'h0003, d);
    do_req(12'h010, 0, 16'h0000, '0);
    do_req(12'h018, 0, 16'h0000, '0);
    do_req(12'h020, 0, 16'h0000, '0);

    // Retry held for three cycles on a refill.
    force_rty3 = 1;
    delay = 3;
    do_req(12'h041, 0, 16'h0000, '0);
    force_rty3 = 0;

    // Randomized traffic on a small footprint so sets conflict often.
    for (int i = 0; i < 300; i++) begin
      int a;
      bit w;
      a = $urandom_range(0, 3) * 8 + $urandom_range(0, 7);
      w = ($urandom_range(0, 9) < 4);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_req(a, w, 16'($urandom), d);
    end

    // Reset during a writeback: leave 0x010 dirty and the LRU of set 0, then miss.
    do_req(12'h010, 1, 16'hFFFF, {4{32'hC0DE_0010}});
    do_req(12'h028, 0, 16'h0000, '0);
    hold_mem = 1;
    @(posedge clk); #1;
    cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_adr = 12'h038; cpu_sel = '0;
    n = 0;
    @(negedge clk);
    while (!(mem_cyc && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wb_started", mem_we, 1);
    check("wb_adr", mem_adr, 12'h010);
    @(posedge clk); #1;
    rst = 1;
    cpu_cyc = 0; cpu_stb = 0;
    @(posedge clk); #1;
    check("rst_abort_mem_cyc", mem_cyc, 0);
    check("rst_abort_mem_stb", mem_stb, 0);
    check("rst_abort_mem_we", mem_we, 0);
    check("rst_abort_miss_count", miss_count, 0);
    rst = 0;
    hold_mem = 0;
    model_reset();
    @(posedge clk); #1;
    do_req(12'h010, 0, 16'h0000, '0);

    repeat (3) @(posedge clk);
    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    check("mem_q_drained", 32'(mem_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
